median_window_sequencer: RTL

- Drives the 9-sample median sorter across a whole stored greyscale image.
- For every output pixel it:
  - fetches the 3x3 neighbourhood from the source pixel RAM, clamping at the edges;
  - streams the 9 samples into the sorter;
  - waits for the median;
  - writes the median to the destination frame RAM.
- Sits between the frame buffers and the sorter. It is the sole owner of the sorter's load/start sequencing.

---
 rtl/median_window_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/median_window_sequencer.sv
// Purpose : walks a stored greyscale frame, feeds each clamped 3x3 neighbourhood to the
//           9-sample median sorter and writes the median to the destination frame RAM.
// Latency : 9 reads + 1 data + 1 start + sorter latency + 1 write cycles per pixel (best case);
// Backpr. : a pixel write holds wr_en/wr_addr/wr_data until wr_ready; no new reads or samples meanwhile.
//
// Ports
//   clk, reset                   : clock, synchronous active-high reset
//   start / busy / done / err    : frame request, in-progress flag, end pulse, sticky sort timeout
//   rd_en, rd_addr, rd_data      : source RAM read port, data returns one cycle after rd_en
//   smp_valid, smp_data          : sample stream into the sorter
//   sort_start, sort_done, sort_median : sorter handshake
//   wr_en, wr_addr, wr_data, wr_ready  : destination RAM write port with ready
module median_window_sequencer #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int AW      = 6,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          smp_valid,
    output logic [DW-1:0] smp_data,
    output logic          sort_start,
    input  logic          sort_done,
    input  logic [DW-1:0] sort_median,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    input  logic          wr_ready
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] XMAX  = AW'(IMG_W - 1);
    localparam logic [AW-1:0] YMAX  = AW'(IMG_H - 1);
    localparam logic [AW-1:0] W_A   = AW'(IMG_W);
    localparam logic [AW-1:0] ONE   = AW'(1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] x, x_nx, y, y_nx;
    logic [3:0]    k, k_nx;          // FETCH phase: 0..8 reads, 1..9 samples, 10 sort_start
    logic [TW-1:0] tcnt, tcnt_nx;
    logic [DW-1:0] wdat, wdat_nx;
    logic          err_q, err_nx;

    logic [1:0]    row, col;
    logic [AW-1:0] nx, ny;

    // Neighbour offset for read k: row = k/3, col = k%3 (offset = value - 1).
    always_comb begin
        row = 2'd2;
        col = 2'(k - 4'd6);
        if (k < 4'd3) begin
            row = 2'd0;
            col = k[1:0];
        end else if (k < 4'd6) begin
            row = 2'd1;
            col = 2'(k - 4'd3);
        end
    end

    // Clamp in coordinate space first so the product never leaves the frame.
    always_comb begin
        nx = x;
        ny = y;
        if (col == 2'd0)      nx = (x == '0)   ? x : x - ONE;
        else if (col == 2'd2) nx = (x == XMAX) ? x : x + ONE;
        if (row == 2'd0)      ny = (y == '0)   ? y : y - ONE;
        else if (row == 2'd2) ny = (y == YMAX) ? y : y + ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            x     <= '0;
            y     <= '0;
            k     <= '0;
            tcnt  <= '0;
            wdat  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            x     <= x_nx;
            y     <= y_nx;
            k     <= k_nx;
            tcnt  <= tcnt_nx;
            wdat  <= wdat_nx;
            err_q <= err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        x_nx       = x;
        y_nx       = y;
        k_nx       = k;
        tcnt_nx    = tcnt;
        wdat_nx    = wdat;
        err_nx     = err_q;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        smp_valid  = 1'b0;
        smp_data   = '0;
        sort_start = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_FETCH;
                    x_nx     = '0;
                    y_nx     = '0;
                    k_nx     = '0;
                    err_nx   = 1'b0;
                end
            end
            S_FETCH: begin
                busy = 1'b1;
                if (k <= 4'd8) begin
                    rd_en   = 1'b1;
                    rd_addr = ny * W_A + nx;
                end
                // Each sample is the RAM data returned for the previous cycle's read.
                if (k >= 4'd1 && k <= 4'd9) begin
                    smp_valid = 1'b1;
                    smp_data  = rd_data;
                end
                if (k == 4'd10) begin
                    sort_start = 1'b1;
                    state_nx   = S_WAIT;
                    k_nx       = '0;
                    tcnt_nx    = '0;
                end else begin
                    k_nx = k + 4'd1;
                end
            end
            S_WAIT: begin
                busy    = 1'b1;
                tcnt_nx = tcnt + TW'(1);
                if (sort_done) begin
                    wdat_nx  = sort_median;
                    state_nx = S_WRITE;
                end else if (tcnt == TLAST) begin
                    // Sorter gave up on this pixel: flag it, write 0 and keep going.
                    err_nx   = 1'b1;
                    wdat_nx  = '0;
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = y * W_A + x;
                if (wr_ready) begin
                    if (x == XMAX && y == YMAX) begin
                        x_nx     = '0;
                        y_nx     = '0;
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_FETCH;
                        k_nx     = '0;
                        if (x == XMAX) begin
                            x_nx = '0;
                            y_nx = y + ONE;
                        end else begin
                            x_nx = x + ONE;
                        end
                    end
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign err     = err_q;
    assign wr_data = wdat;

endmodule
